// File: rtl/clock_control.sv
`default_nettype none
// ============================================================================
// Module   : clock_control
// Brief    : CPU clock generator with continuous/single-step modes and halt.
// Revision : 1.0
// ============================================================================
module clock_control #(
    parameter int DIV_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 button,
    input  logic                 hlt,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 cpu_clk,
    output logic                 cpu_tick,
    output logic                 halted,
    output logic [1:0]           state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_HIGH = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] phase_q, phase_d;
    logic                 cpu_clk_q, cpu_clk_d;
    logic                 tick_q, tick_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 deb_q, deb_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                 step_req_q, step_req_d;
    logic                 w_rise_evt;

    // Button path: synchronizer, debouncer, rising-edge detector
    always_comb begin
        sync1_d  = button;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (db_cnt_q == c_db_last) begin
                deb_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        step_req_d = deb_d & ~deb_q;
    end

    // In manual mode only a press can raise the clock; in continuous mode
    // only the phase counter can, so stray presses are simply dropped.
    assign w_rise_evt = mode ? step_req_q : (phase_q >= div);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cpu_clk_d = cpu_clk_q;
        tick_d    = 1'b0;
        case (state_q)
            ST_LOW: begin
                cpu_clk_d = 1'b0;
                if (w_rise_evt) begin
                    phase_d = '0;
                    if (hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d   = ST_HIGH;
                        cpu_clk_d = 1'b1;
                        tick_d    = 1'b1;
                    end
                end else begin
                    phase_d = mode ? '0 : phase_q + DIV_WIDTH'(1);
                end
            end
            ST_HIGH: begin
                cpu_clk_d = 1'b1;
                if (phase_q >= div) begin
                    state_d   = ST_LOW;
                    cpu_clk_d = 1'b0;
                    phase_d   = '0;
                end else begin
                    phase_d = phase_q + DIV_WIDTH'(1);
                end
            end
            ST_HALT: begin
                cpu_clk_d = 1'b0;
                phase_d   = '0;
            end
            default: begin
                state_d   = ST_LOW;
                cpu_clk_d = 1'b0;
                phase_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOW;
            phase_q    <= '0;
            cpu_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            db_cnt_q   <= '0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cpu_clk_q  <= cpu_clk_d;
            tick_q     <= tick_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            step_req_q <= step_req_d;
        end
    end

    assign cpu_clk  = cpu_clk_q;
    assign cpu_tick = tick_q;
    assign halted   = (state_q == ST_HALT);
    assign state    = state_q;

endmodule
`default_nettype wire
